// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and default constants for the M/N divider ratio monitor.
//   state_t : monitor FSM states
//   M_N     : measurement window length in source cycles
//   N       : expected rising-edge count inside one window
//   PER_MIN : smallest legal divided-clock period
//   PER_MAX : largest legal divided-clock period
//   ARM_TO  : source cycles allowed while waiting for the arming edge
//   CW      : width of counters and result fields
// -----------------------------------------------------------------------------
package div_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int M_N     = 87;
   localparam int N       = 10;
   localparam int PER_MIN = 8;
   localparam int PER_MAX = 9;
   localparam int ARM_TO  = 32;
   localparam int CW      = 8;

endpackage

// File: rtl/div_ratio_monitor_if.sv
// -----------------------------------------------------------------------------
// div_ratio_monitor_if
// Control, sampled divider input and result bundle of the ratio monitor.
//   start       : one-cycle measurement request
//   div_in      : divider output, synchronous to the source clock
//   busy        : monitor not idle
//   done        : one-cycle pulse, results valid from this cycle
//   pass        : window matched the expected ratio with no error
//   err_period  : a period fell outside the legal range
//   err_noclk   : no arming edge arrived in time
//   edge_cnt    : rising edges counted in the window
//   per_last    : last completed period
//   per_min_obs : smallest completed period
//   per_max_obs : largest completed period
// Modports: master drives start/div_in, slave is the monitor.
// -----------------------------------------------------------------------------
interface div_ratio_monitor_if #(
   parameter int CW = div_pkg::CW
);

   logic          start;
   logic          div_in;
   logic          busy;
   logic          done;
   logic          pass;
   logic          err_period;
   logic          err_noclk;
   logic [CW-1:0] edge_cnt;
   logic [CW-1:0] per_last;
   logic [CW-1:0] per_min_obs;
   logic [CW-1:0] per_max_obs;

   modport master (
      output start, div_in,
      input  busy, done, pass, err_period, err_noclk,
      input  edge_cnt, per_last, per_min_obs, per_max_obs
   );

   modport slave (
      input  start, div_in,
      output busy, done, pass, err_period, err_noclk,
      output edge_cnt, per_last, per_min_obs, per_max_obs
   );

endinterface

// File: rtl/div_edge_det.sv
// -----------------------------------------------------------------------------
// div_edge_det
// Samples the divided clock as data and flags its rising edges.
//   clk_in : source clock
//   rst    : synchronous active-high reset
//   div_in : divider output, synchronous to clk_in
//   rise   : high for one cycle, one cycle after div_in is first sampled high
// -----------------------------------------------------------------------------
module div_edge_det (
   input  logic clk_in,
   input  logic rst,
   input  logic div_in,
   output logic rise
);

   logic div_s;
   logic div_p;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         div_s <= 1'b0;
         div_p <= 1'b0;
      end else begin
         div_s <= div_in;
         div_p <= div_s;
      end
   end

   assign rise = div_s & ~div_p;

endmodule

// File: rtl/div_ratio_monitor.sv
// -----------------------------------------------------------------------------
// div_ratio_monitor
// Checks a fractional M/N divider output over one window of WIN source
// cycles: counts rising edges, tracks period length and min/max period, and
// reports pass/fail against the expected edge count and legal period range.
//   clk_in : source clock (single clock domain)
//   rst    : synchronous active-high reset, abandons any measurement
//   bus    : slave side of div_ratio_monitor_if (start/div_in in, results out)
// -----------------------------------------------------------------------------
module div_ratio_monitor
   import div_pkg::*;
#(
   parameter int WIN       = div_pkg::M_N,
   parameter int EXP_EDGES = div_pkg::N,
   parameter int PER_MIN   = div_pkg::PER_MIN,
   parameter int PER_MAX   = div_pkg::PER_MAX,
   parameter int ARM_TO    = div_pkg::ARM_TO,
   parameter int CW        = div_pkg::CW
) (
   input  logic             clk_in,
   input  logic             rst,
   div_ratio_monitor_if.slave bus
);

   state_t        state;
   state_t        state_nxt;
   logic          rise;

   logic [CW-1:0] arm_cnt;
   logic [CW-1:0] win_cnt;
   logic [CW-1:0] per_cnt;
   logic [CW-1:0] per_nxt;

   logic [CW-1:0] edge_cnt;
   logic [CW-1:0] per_last;
   logic [CW-1:0] per_min_obs;
   logic [CW-1:0] per_max_obs;
   logic          err_period;
   logic          err_noclk;
   logic          pass_r;
   logic          pass_now;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   div_edge_det u_edge_det (
      .clk_in (clk_in),
      .rst    (rst),
      .div_in (bus.div_in),
      .rise   (rise)
   );

   always_ff @(posedge clk_in) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = ARM;
         ARM: begin
            if (rise)                              state_nxt = MEASURE;
            else if (arm_cnt == CW'(ARM_TO - 1))   state_nxt = DONE;
         end
         MEASURE: if (win_cnt == CW'(WIN - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Running period value if no edge arrives this cycle; checked against the
   // upper bound so a stuck divider is flagged as soon as it overruns.
   assign per_nxt  = sat_inc(per_cnt);
   assign pass_now = (edge_cnt == CW'(EXP_EDGES)) & ~err_period & ~err_noclk;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         arm_cnt     <= '0;
         win_cnt     <= '0;
         per_cnt     <= '0;
         edge_cnt    <= '0;
         per_last    <= '0;
         per_min_obs <= '0;
         per_max_obs <= '0;
         err_period  <= 1'b0;
         err_noclk   <= 1'b0;
         pass_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A rise coinciding with start is deliberately not used.
               if (bus.start) begin
                  arm_cnt     <= '0;
                  edge_cnt    <= '0;
                  per_last    <= '0;
                  per_min_obs <= '1;
                  per_max_obs <= '0;
                  err_period  <= 1'b0;
                  err_noclk   <= 1'b0;
                  pass_r      <= 1'b0;
               end
            end
            ARM: begin
               // The arming edge opens the window but is not itself counted.
               if (rise) begin
                  win_cnt <= '0;
                  per_cnt <= CW'(1);
               end else if (arm_cnt == CW'(ARM_TO - 1)) begin
                  err_noclk <= 1'b1;
               end else begin
                  arm_cnt <= sat_inc(arm_cnt);
               end
            end
            MEASURE: begin
               win_cnt <= sat_inc(win_cnt);
               if (rise) begin
                  per_last <= per_cnt;
                  if (per_cnt < per_min_obs) per_min_obs <= per_cnt;
                  if (per_cnt > per_max_obs) per_max_obs <= per_cnt;
                  if ((per_cnt < CW'(PER_MIN)) || (per_cnt > CW'(PER_MAX)))
                     err_period <= 1'b1;
                  edge_cnt <= sat_inc(edge_cnt);
                  per_cnt  <= CW'(1);
               end else begin
                  per_cnt <= per_nxt;
                  if (per_nxt > CW'(PER_MAX)) err_period <= 1'b1;
               end
            end
            DONE: pass_r <= pass_now;
            default: ;
         endcase
      end
   end

   // pass is live during the done cycle, then held in pass_r.
   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == DONE);
   assign bus.pass        = (state == DONE) ? pass_now : pass_r;
   assign bus.err_period  = err_period;
   assign bus.err_noclk   = err_noclk;
   assign bus.edge_cnt    = edge_cnt;
   assign bus.per_last    = per_last;
   assign bus.per_min_obs = per_min_obs;
   assign bus.per_max_obs = per_max_obs;

endmodule

// File: tb/tb_div_ratio_monitor.sv
// -----------------------------------------------------------------------------
// tb_div_ratio_monitor
// Scoreboard bench for div_ratio_monitor: directed divider streams are played
// cycle by cycle; hand-computed results are queued when a test is issued and a
// monitor compares them whenever done is presented.
// -----------------------------------------------------------------------------
module tb_div_ratio_monitor;

   logic clk_in = 1'b0;
   logic rst;

   div_ratio_monitor_if bus ();

   div_ratio_monitor dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      int id;
      int edges;
      int last;
      int pmin;
      int pmax;
      int errp;
      int errnc;
      int pass;
      int lat;
   } exp_t;

   exp_t sb[$];
   exp_t e_cur;
   logic bits[$];

   int n_tot   = 0;
   int n_bad   = 0;
   int n_done  = 0;
   int t_start = 0;

   task automatic chk(input int id, input string nm, input int act, input int req);
      n_tot++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL t%0d %s: got %0d want %0d", id, nm, act, req);
      end
   endtask

   task automatic check_reset(input int id);
      chk(id, "rst_busy",       int'(bus.busy),        0);
      chk(id, "rst_done",       int'(bus.done),        0);
      chk(id, "rst_pass",       int'(bus.pass),        0);
      chk(id, "rst_err_period", int'(bus.err_period),  0);
      chk(id, "rst_err_noclk",  int'(bus.err_noclk),   0);
      chk(id, "rst_edge_cnt",   int'(bus.edge_cnt),    0);
      chk(id, "rst_per_last",   int'(bus.per_last),    0);
      chk(id, "rst_per_min",    int'(bus.per_min_obs), 0);
      chk(id, "rst_per_max",    int'(bus.per_max_obs), 0);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk_in) begin
      if (bus.done === 1'b1) begin
         n_done++;
         if (sb.size() == 0) begin
            chk(0, "done_without_expect", int'(bus.done), 0);
         end else begin
            e_cur = sb.pop_front();
            chk(e_cur.id, "edge_cnt",   int'(bus.edge_cnt),    e_cur.edges);
            chk(e_cur.id, "per_last",   int'(bus.per_last),    e_cur.last);
            chk(e_cur.id, "per_min",    int'(bus.per_min_obs), e_cur.pmin);
            chk(e_cur.id, "per_max",    int'(bus.per_max_obs), e_cur.pmax);
            chk(e_cur.id, "err_period", int'(bus.err_period),  e_cur.errp);
            chk(e_cur.id, "err_noclk",  int'(bus.err_noclk),   e_cur.errnc);
            chk(e_cur.id, "pass",       int'(bus.pass),        e_cur.pass);
            chk(e_cur.id, "latency",    cyc - t_start,         e_cur.lat);
         end
      end
   end

   task automatic push_exp(input int id, input int edges, input int last, input int pmin,
                           input int pmax, input int errp, input int errnc, input int pass,
                           input int lat);
      exp_t e;
      e.id = id; e.edges = edges; e.last = last; e.pmin = pmin; e.pmax = pmax;
      e.errp = errp; e.errnc = errnc; e.pass = pass; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic add_period(input int p);
      for (int k = 0; k < p; k++) bits.push_back(k < 4);
   endtask

   task automatic add_const(input int n, input logic v);
      for (int k = 0; k < n; k++) bits.push_back(v);
   endtask

   task automatic add_good_stream();
      repeat (2) begin
         repeat (3) add_period(8);
         repeat (7) add_period(9);
      end
   endtask

   // Plays bits[] one value per cycle; start at start_j (and optionally again
   // at start2_j), rst pulsed at rst_j, reset state checked the cycle after.
   task automatic play(input int start_j, input int start2_j, input int rst_j);
      for (int j = 0; j < bits.size(); j++) begin
         @(negedge clk_in);
         if (rst_j >= 0 && j == rst_j + 1) check_reset(6);
         bus.start  = (j == start_j) || (j == start2_j);
         bus.div_in = bits[j];
         rst        = (j == rst_j);
         if (j == start_j) t_start = cyc + 1;
      end
      @(negedge clk_in);
      bus.start  = 1'b0;
      bus.div_in = 1'b0;
      rst        = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_in);
         bus.start  = 1'b0;
         bus.div_in = 1'b0;
      end
   endtask

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.div_in = 1'b0;
      repeat (3) @(negedge clk_in);
      check_reset(0);
      rst = 1'b0;
      idle(3);

      // 1: 3x8 + 7x9 stream, arming on first edge
      bits.delete(); add_const(3, 1'b0); add_good_stream(); add_const(5, 1'b0);
      push_exp(1, 10, 9, 8, 9, 0, 0, 1, 91);
      play(0, -1, -1);
      idle(5);

      // 2: no clock
      bits.delete(); add_const(40, 1'b0);
      push_exp(2, 0, 0, 255, 0, 0, 1, 0, 32);
      play(0, -1, -1);
      idle(5);

      // 3: divide-by-7
      bits.delete(); add_const(3, 1'b0);
      repeat (15) add_period(7);
      add_const(5, 1'b0);
      push_exp(3, 12, 7, 7, 7, 1, 0, 0, 91);
      play(0, -1, -1);
      idle(5);

      // 4: stuck high after the 5th counted edge
      bits.delete(); add_const(3, 1'b0);
      add_period(8); add_period(8); add_period(8); add_period(9); add_period(9);
      add_const(100, 1'b1); add_const(5, 1'b0);
      push_exp(4, 5, 9, 8, 9, 1, 0, 0, 91);
      play(0, -1, -1);
      idle(5);

      // 5: second start during MEASURE is ignored
      bits.delete(); add_const(3, 1'b0); add_good_stream(); add_const(5, 1'b0);
      push_exp(5, 10, 9, 8, 9, 0, 0, 1, 91);
      play(0, 40, -1);
      idle(5);

      // 6: reset during MEASURE, no done expected
      bits.delete(); add_const(3, 1'b0); add_good_stream(); add_const(5, 1'b0);
      play(0, -1, 45);
      idle(100);

      // 7: start coincides with a rise; arming on the following edge
      bits.delete(); add_const(2, 1'b0); add_good_stream(); add_const(5, 1'b0);
      push_exp(7, 10, 8, 8, 9, 0, 0, 1, 95);
      play(3, -1, -1);
      idle(5);

      for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk_in);
      chk(0, "pending_expect", sb.size(), 0);
      chk(0, "done_count", n_done, 6);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/div_ratio_monitor.md
Name: div_ratio_monitor

Overview:
Downstream checker for the fractional M/N clock divider output. Treats the divided clock as data in the clk_in domain. On each start it measures one window of WIN source cycles: rising-edge count, each period length, min/max period. It then reports pass/fail against the expected ratio (87 cycles / 10 edges, periods 8 or 9). Used in bring-up and self-test to confirm the divider's average ratio and its period pattern.

Parameters:
WIN, 87, measurement window length in clk_in cycles (M_N)
EXP_EDGES, 10, required rising-edge count inside the window
PER_MIN, 8, smallest legal period (clk_in cycles)
PER_MAX, 9, largest legal period (clk_in cycles)
ARM_TO, 32, clk_in cycles allowed in ARM before declaring no clock
CW, 8, width of all counters and result fields

Ports:
clk_in  input  1  source clock; single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a measurement; ignored unless IDLE
div_in  input  1  divider output, synchronous to clk_in
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; results valid from this cycle
pass  output  1  edge_cnt==EXP_EDGES and no error
err_period  output  1  some period fell outside [PER_MIN,PER_MAX], or the running period exceeded PER_MAX
err_noclk  output  1  no rising edge within ARM_TO cycles of ARM
edge_cnt  output  CW  rising edges counted in window
per_last  output  CW  last completed period length
per_min_obs  output  CW  smallest completed period
per_max_obs  output  CW  largest completed period

Behaviour:
- Reset (rst high at a clk_in edge): state IDLE, all outputs 0, internal samples 0. Applies mid-operation; the measurement is abandoned, no done pulse.
- Edge detect: div_s <= div_in; div_p <= div_s; rise = div_s & ~div_p. Rise is asserted one cycle after div_in is first sampled high.
- IDLE: on start, go to ARM. Clear edge_cnt, per_last, per_max_obs, err_period, err_noclk and pass; set per_min_obs to all-ones. A rise in the start cycle is ignored. start when not IDLE is ignored.
- ARM: arm_cnt counts from 0.
  - On rise: go to MEASURE, win_cnt<=0, per_cnt<=1. The arming edge is not counted.
  - If arm_cnt==ARM_TO-1 with no rise: err_noclk<=1, go to DONE.
- MEASURE, every cycle, win_cnt++:
  - On rise: per_last<=per_cnt; min/max updated; err_period<=1 (sticky) if per_cnt<PER_MIN or per_cnt>PER_MAX; edge_cnt++ (saturating); per_cnt<=1.
  - No rise: per_cnt++ (saturating at all-ones). If the new value exceeds PER_MAX, err_period<=1 immediately.
  - When win_cnt==WIN-1, that cycle is processed normally (a rise is counted), then go to DONE.
- DONE: lasts one cycle. done=1; pass=(edge_cnt==EXP_EDGES) & ~err_period & ~err_noclk. Then go to IDLE.
- Result outputs hold until the next accepted start.
- Any 10 consecutive periods of a correct 87/10 stream sum to 87, so arming on any edge yields edge_cnt=10.
- Latency: done asserts WIN+1 cycles after the arming rise.

Decomposition:
- Shared package div_pkg: state enum {IDLE, ARM, MEASURE, DONE}; default constants M_N=87, N=10, PER_MIN=8, PER_MAX=9.
- One sub-module: div_edge_det (two-flop sample, rise output, synchronous reset).
- FSM, counters and result registers stay in div_ratio_monitor.

Test Plan:
- Repeating 3×period-8 then 7×period-9 stream, start once -> done after 88 cycles from the arming rise; edge_cnt=10, min=8, max=9, pass=1, both errors 0.
- div_in held 0, start -> done 33 cycles after start (1 cycle in IDLE→ARM plus 32 in ARM); err_noclk=1, edge_cnt=0, pass=0.
- Divide-by-7 stream -> edge_cnt=12, per_min_obs=7, per_max_obs=7, err_period=1, pass=0.
- Valid stream, div_in stuck high after the 5th counted edge -> err_period set when per_cnt reaches 10; edge_cnt=5; done still at window end; pass=0.
- start pulsed during MEASURE -> ignored, single done. rst during MEASURE -> next cycle busy=0 and all outputs 0; no done.
- start coincident with a rise in IDLE -> that rise is not used for arming; arming occurs on the next rise.
